// File: rtl/fir_ram_pkg.sv
// Shared FIR coefficient SRAM definitions.
// Used by the RAM controller, its address sequencer and the SRAM.
package fir_ram_pkg;

  localparam int RAM_ADDR_W     = 6;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_DEPTH = 33;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    FLUSH = 2'd3
  } ramStateT;

  function automatic logic [RAM_ADDR_W-1:0] depthToAddr(
    input int depth
  );
    return RAM_ADDR_W'(depth);
  endfunction

endpackage

// File: rtl/fir_ram_addr_seq.sv
// Coefficient address counter 1..ADDR_DEPTH.
// Load returns to 1 and wins over enable; oLast flags ADDR_DEPTH.
module fir_ram_addr_seq
  import fir_ram_pkg::*;
#(
  parameter int ADDR_DEPTH = DEF_ADDR_DEPTH
) (
  input  logic                  iClk_12M,
  input  logic                  iRsn,
  input  logic                  iLoad,
  input  logic                  iEn,
  output logic [RAM_ADDR_W-1:0] oCnt,
  output logic                  oLast
);

  // Address counter: address 0 is never produced
  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      oCnt <= RAM_ADDR_W'(1);
    end else if (iLoad) begin
      oCnt <= RAM_ADDR_W'(1);
    end else if (iEn) begin
      oCnt <= oCnt + 1'b1;
    end
  end

  assign oLast = (oCnt == depthToAddr(ADDR_DEPTH));

endmodule

// File: rtl/fir_coeff_ram_ctrl.sv
// FIR coefficient SRAM initiator: stream load, then sequential read sweep.
// Optional COEFF_RD_WRAP_EN: iRdStart held at the last address repeats the sweep.
module fir_coeff_ram_ctrl
  import fir_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_DEPTH = DEF_ADDR_DEPTH
) (
  input  logic                  iClk_12M,
  input  logic                  iRsn,
  input  logic                  iCoeffUpdate,
  input  logic                  iCoeffInValid,
  input  logic [DATA_WIDTH-1:0] iCoeffIn,
  output logic                  oCoeffInReady,
  input  logic                  iRdStart,
  output logic [DATA_WIDTH-1:0] oCoeffOut,
  output logic                  oCoeffOutValid,
  output logic                  oCoeffLast,
  output logic                  oBusy,
  output logic                  oCsnRam,
  output logic                  oWrnRam,
  output logic [RAM_ADDR_W-1:0] oAddrRam,
  output logic [DATA_WIDTH-1:0] oWrDtRam,
  input  logic [DATA_WIDTH-1:0] iRdDtRam
);

  ramStateT state;
  ramStateT nextState;

  logic                  flushCnt;
  logic                  cntLoad;
  logic                  cntEn;
  logic [RAM_ADDR_W-1:0] cnt;
  logic                  cntLast;

  logic                  csnD;
  logic                  wrnD;
  logic [RAM_ADDR_W-1:0] addrD;
  logic [DATA_WIDTH-1:0] wrDtD;

  logic                  rdPipe;
  logic                  rdLastPipe;
  logic                  reqRd;
  logic                  reqLast;

  fir_ram_addr_seq #(
    .ADDR_DEPTH (ADDR_DEPTH)
  ) uAddrSeq (
    .iClk_12M (iClk_12M),
    .iRsn     (iRsn),
    .iLoad    (cntLoad),
    .iEn      (cntEn),
    .oCnt     (cnt),
    .oLast    (cntLast)
  );

  // State register plus the two-cycle drain counter for FLUSH
  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      state    <= IDLE;
      flushCnt <= 1'b0;
    end else begin
      state    <= nextState;
      flushCnt <= (state == FLUSH) && !flushCnt;
    end
  end

  // Next state: update beats read start when both arrive together
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (iCoeffUpdate) begin
          nextState = WR;
        end else if (iRdStart) begin
          nextState = RD;
        end
      end
      WR: begin
        if (iCoeffInValid && cntLast) begin
          nextState = IDLE;
        end
      end
      RD: begin
        if (cntLast) begin
`ifdef COEFF_RD_WRAP_EN
          nextState = iRdStart ? RD : FLUSH;
`else
          nextState = FLUSH;
`endif
        end
      end
      FLUSH: begin
        if (flushCnt) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Output decode: next values for the registered SRAM port
  always_comb begin
    csnD  = 1'b1;
    wrnD  = 1'b1;
    addrD = oAddrRam;
    wrDtD = oWrDtRam;
    cntEn = 1'b0;
    unique case (state)
      WR: begin
        if (iCoeffInValid) begin
          csnD  = 1'b0;
          wrnD  = 1'b0;
          addrD = cnt;
          wrDtD = iCoeffIn;
          cntEn = 1'b1;
        end
      end
      RD: begin
        csnD  = 1'b0;
        addrD = cnt;
        cntEn = 1'b1;
      end
      default: begin
        csnD = 1'b1;
      end
    endcase
    cntLoad = (state == IDLE) || (cntEn && cntLast);
  end

  assign reqRd   = !oCsnRam && oWrnRam;
  assign reqLast = reqRd && (oAddrRam == depthToAddr(ADDR_DEPTH));

  // Registered outputs and read-data alignment pipeline
  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      oCsnRam        <= 1'b1;
      oWrnRam        <= 1'b1;
      oAddrRam       <= '0;
      oWrDtRam       <= '0;
      oCoeffInReady  <= 1'b0;
      oBusy          <= 1'b0;
      rdPipe         <= 1'b0;
      rdLastPipe     <= 1'b0;
      oCoeffOut      <= '0;
      oCoeffOutValid <= 1'b0;
      oCoeffLast     <= 1'b0;
    end else begin
      oCsnRam        <= csnD;
      oWrnRam        <= wrnD;
      oAddrRam       <= addrD;
      oWrDtRam       <= wrDtD;
      oCoeffInReady  <= (nextState == WR);
      oBusy          <= (nextState != IDLE);
      rdPipe         <= reqRd;
      rdLastPipe     <= reqLast;
      oCoeffOutValid <= rdPipe;
      oCoeffLast     <= rdLastPipe;
      if (rdPipe) begin
        oCoeffOut <= iRdDtRam;
      end
    end
  end

endmodule

// File: tb/tb_fir_coeff_ram_ctrl.sv
// Directed bench for fir_coeff_ram_ctrl with a behavioural SRAM.
// Wrap sweep is exercised when COEFF_RD_WRAP_EN is defined.
module tb_fir_coeff_ram_ctrl;

  logic        iClk_12M = 1'b0;
  logic        iRsn;
  logic        iCoeffUpdate;
  logic        iCoeffInValid;
  logic [15:0] iCoeffIn;
  logic        oCoeffInReady;
  logic        iRdStart;
  logic [15:0] oCoeffOut;
  logic        oCoeffOutValid;
  logic        oCoeffLast;
  logic        oBusy;
  logic        oCsnRam;
  logic        oWrnRam;
  logic [5:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic [15:0] iRdDtRam;

  logic [15:0] ramMem [0:63];
  logic [15:0] expMem [1:33];
  logic [15:0] wrData [1:33];

  int nChecks = 0;
  int nPass   = 0;

  always #42 iClk_12M = ~iClk_12M;

  fir_coeff_ram_ctrl dut (
    .iClk_12M       (iClk_12M),
    .iRsn           (iRsn),
    .iCoeffUpdate   (iCoeffUpdate),
    .iCoeffInValid  (iCoeffInValid),
    .iCoeffIn       (iCoeffIn),
    .oCoeffInReady  (oCoeffInReady),
    .iRdStart       (iRdStart),
    .oCoeffOut      (oCoeffOut),
    .oCoeffOutValid (oCoeffOutValid),
    .oCoeffLast     (oCoeffLast),
    .oBusy          (oBusy),
    .oCsnRam        (oCsnRam),
    .oWrnRam        (oWrnRam),
    .oAddrRam       (oAddrRam),
    .oWrDtRam       (oWrDtRam),
    .iRdDtRam       (iRdDtRam)
  );

  // Single-port SRAM, registered read, cleared by the shared reset
  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      for (int i = 0; i < 64; i++) ramMem[i] <= '0;
      iRdDtRam <= '0;
    end else if (!oCsnRam) begin
      if (!oWrnRam) ramMem[oAddrRam] <= oWrDtRam;
      else iRdDtRam <= ramMem[oAddrRam];
    end
  end

  task automatic tick();
    @(posedge iClk_12M);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic checkResetOuts(input string tag);
    check({tag, "_csn"},   32'(oCsnRam), 32'd1);
    check({tag, "_wrn"},   32'(oWrnRam), 32'd1);
    check({tag, "_addr"},  32'(oAddrRam), 32'd0);
    check({tag, "_wrdt"},  32'(oWrDtRam), 32'd0);
    check({tag, "_rdy"},   32'(oCoeffInReady), 32'd0);
    check({tag, "_out"},   32'(oCoeffOut), 32'd0);
    check({tag, "_vld"},   32'(oCoeffOutValid), 32'd0);
    check({tag, "_last"},  32'(oCoeffLast), 32'd0);
    check({tag, "_busy"},  32'(oBusy), 32'd0);
  endtask

  task automatic doLoad(
    input bit gaps,
    input bit alsoRd,
    input int nWords
  );
    iCoeffUpdate = 1'b1;
    iRdStart     = alsoRd;
    tick();
    iCoeffUpdate = 1'b0;
    check("ld_rdy", 32'(oCoeffInReady), 32'd1);
    check("ld_busy", 32'(oBusy), 32'd1);
    for (int i = 1; i <= nWords; i++) begin
      iCoeffInValid = 1'b1;
      iCoeffIn      = wrData[i];
      tick();
      check($sformatf("wr_csn%0d", i), 32'(oCsnRam), 32'd0);
      check($sformatf("wr_wrn%0d", i), 32'(oWrnRam), 32'd0);
      check($sformatf("wr_addr%0d", i), 32'(oAddrRam), i);
      check($sformatf("wr_dt%0d", i), 32'(oWrDtRam), 32'(wrData[i]));
      expMem[i] = wrData[i];
      if (i == 33) begin
        check("wr_rdy_drop", 32'(oCoeffInReady), 32'd0);
        check("wr_busy_drop", 32'(oBusy), 32'd0);
      end
      iCoeffInValid = 1'b0;
      if (gaps) begin
        tick();
        check($sformatf("gap_csn%0d", i), 32'(oCsnRam), 32'd1);
        check($sformatf("gap_addr%0d", i), 32'(oAddrRam), i);
      end
    end
    iRdStart = 1'b0;
  endtask

  task automatic rdSweep(
    input int nVal,
    input int holdEdges
  );
    int k;
    iRdStart = 1'b1;
    tick();
    for (int e = 1; e <= nVal + 3; e++) begin
      iRdStart = (e <= holdEdges);
      tick();
      if (e <= nVal) begin
        check($sformatf("rd_csn%0d", e), 32'(oCsnRam), 32'd0);
        check($sformatf("rd_addr%0d", e), 32'(oAddrRam),
              ((e - 1) % 33) + 1);
      end
      if (e < 3 || e > nVal + 2) begin
        check($sformatf("rd_novld%0d", e), 32'(oCoeffOutValid), 32'd0);
      end else begin
        k = e - 3;
        check($sformatf("rd_vld%0d", k), 32'(oCoeffOutValid), 32'd1);
        check($sformatf("rd_dt%0d", k), 32'(oCoeffOut),
              32'(expMem[(k % 33) + 1]));
        check($sformatf("rd_last%0d", k), 32'(oCoeffLast),
              32'((k % 33) == 32));
      end
    end
    check("rd_end_busy", 32'(oBusy), 32'd0);
    check("rd_end_csn", 32'(oCsnRam), 32'd1);
    iRdStart = 1'b0;
  endtask

  initial begin
    iRsn          = 1'b0;
    iCoeffUpdate  = 1'b0;
    iCoeffInValid = 1'b0;
    iCoeffIn      = '0;
    iRdStart      = 1'b0;
    tick();
    tick();
    checkResetOuts("rst");
    iRsn = 1'b1;
    tick();

    for (int i = 1; i <= 33; i++) wrData[i] = 16'(i);
    doLoad(1'b0, 1'b0, 33);
    tick();
    rdSweep(33, 0);

    for (int i = 1; i <= 33; i++) wrData[i] = 16'h0100 + 16'(i);
    wrData[1] = 16'h8000;
    wrData[2] = 16'hFFFF;
    wrData[3] = 16'h7FFF;
    doLoad(1'b1, 1'b0, 33);
    tick();
    rdSweep(33, 0);

    for (int i = 1; i <= 33; i++) wrData[i] = 16'(i) * 16'h0111;
    doLoad(1'b0, 1'b1, 10);
    iRsn = 1'b0;
    tick();
    checkResetOuts("midrst");
    iRsn = 1'b1;
    for (int i = 1; i <= 33; i++) expMem[i] = '0;
    tick();
    rdSweep(33, 0);

    for (int i = 1; i <= 33; i++) wrData[i] = 16'hA000 ^ 16'(i);
    doLoad(1'b0, 1'b0, 33);
    tick();
`ifdef COEFF_RD_WRAP_EN
    rdSweep(66, 33);
`else
    rdSweep(33, 10);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
